// File: rtl/fetch_unit_if.sv
// Bus bundle for fetch_unit: icache lookup/refill, memory miss handshake and the
// decode-side instruction queue port. The master modport is the fetch unit side.
interface fetch_unit_if #(
  parameter int VADDR_W    = 32,
  parameter int INST_W     = 32,
  parameter int LINE_W     = 128,
  parameter int MEM_ADDR_W = 32
);
  logic                  redirect_valid;
  logic [VADDR_W-1:0]    redirect_pc;
  logic [VADDR_W-1:0]    ic_addr;
  logic                  ic_hit;
  logic [INST_W-1:0]     ic_instr;
  logic                  ic_fill_en;
  logic [VADDR_W-1:0]    ic_fill_addr;
  logic [LINE_W-1:0]     ic_fill_line;
  logic                  mem_req;
  logic [MEM_ADDR_W-1:0] mem_req_addr;
  logic                  mem_data_rdy;
  logic [LINE_W-1:0]     mem_data;
  logic                  dec_ready;
  logic                  inst_valid;
  logic [INST_W-1:0]     inst;
  logic [VADDR_W-1:0]    inst_pc;

  modport master (
    input  redirect_valid, redirect_pc, ic_hit, ic_instr, mem_data_rdy, mem_data, dec_ready,
    output ic_addr, ic_fill_en, ic_fill_addr, ic_fill_line, mem_req, mem_req_addr,
           inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, ic_hit, ic_instr, mem_data_rdy, mem_data, dec_ready,
    input  ic_addr, ic_fill_en, ic_fill_addr, ic_fill_line, mem_req, mem_req_addr,
           inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC, icache lookup, miss/refill FSM (LOOKUP/MISS/FILL) and a QDEPTH-entry
// instruction queue toward decode. Define FETCH_PERF_CNT_EN to add saturating perf counters.
module fetch_unit #(
  parameter int                VADDR_W    = 32,
  parameter int                INST_W     = 32,
  parameter int                LINE_W     = 128,
  parameter int                MEM_ADDR_W = 32,
  parameter logic [VADDR_W-1:0] BOOT_PC   = VADDR_W'(32'h0000_1000),
  parameter int                QDEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  fetch_unit_if.master bus,
  output logic [1:0] fetch_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_miss_cnt,
  output logic [31:0] perf_redirect_cnt,
  output logic [31:0] perf_qfull_cnt
`endif
);

  localparam int QAW = $clog2(QDEPTH);
  localparam logic [VADDR_W-1:0] PC_INC    = VADDR_W'(INST_W / 8);
  localparam logic [VADDR_W-1:0] INST_MASK = ~(VADDR_W'((INST_W / 8) - 1));
  localparam logic [VADDR_W-1:0] LINE_MASK = ~(VADDR_W'((LINE_W / 8) - 1));
  localparam logic [QAW:0]       QFULL     = (QAW + 1)'(QDEPTH);

  typedef enum logic [1:0] {S_LOOKUP = 2'd0, S_MISS = 2'd1, S_FILL = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [VADDR_W-1:0] pc_q, pc_d;
  logic [VADDR_W-1:0] line_addr_q;
  logic [VADDR_W-1:0] pend_pc_q;
  logic               pend_valid_q;
  logic [LINE_W-1:0]  fill_line_q;
  logic [VADDR_W-1:0] redir_pc;

  logic [INST_W-1:0]  q_inst [QDEPTH];
  logic [VADDR_W-1:0] q_pc   [QDEPTH];
  logic [QAW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [QAW:0]       count_q;
  logic               q_full, q_empty, enq, deq, lookup_miss;

  assign redir_pc = bus.redirect_pc & INST_MASK;
  assign q_full   = (count_q == QFULL);
  assign q_empty  = (count_q == '0);

  // Decode handshake: an entry leaves the queue on a cycle where inst_valid and
  // dec_ready are both high; a redirect in that cycle flushes instead.
  assign deq         = !q_empty && bus.dec_ready && !bus.redirect_valid;
  assign enq         = (state_q == S_LOOKUP) && bus.ic_hit && !bus.redirect_valid && (!q_full || deq);
  assign lookup_miss = (state_q == S_LOOKUP) && !bus.ic_hit && !bus.redirect_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_LOOKUP: begin
        if (bus.redirect_valid)  pc_d    = redir_pc;
        else if (!bus.ic_hit)    state_d = S_MISS;
        else if (enq)            pc_d    = pc_q + PC_INC;
      end
      S_MISS: begin
        if (bus.mem_data_rdy) state_d = S_FILL;
      end
      S_FILL: begin
        state_d = S_LOOKUP;
        if (bus.redirect_valid)  pc_d = redir_pc;
        else if (pend_valid_q)   pc_d = pend_pc_q;
      end
      default: state_d = S_LOOKUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LOOKUP;
      pc_q         <= BOOT_PC;
      line_addr_q  <= '0;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      fill_line_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (lookup_miss) line_addr_q <= pc_q & LINE_MASK;
      if ((state_q == S_MISS) && bus.mem_data_rdy) fill_line_q <= bus.mem_data;
      // A redirect during FILL is applied directly to the PC, so pending is dropped there.
      if (state_q == S_FILL) begin
        pend_valid_q <= 1'b0;
      end else if ((state_q == S_MISS) && bus.redirect_valid) begin
        pend_valid_q <= 1'b1;
        pend_pc_q    <= redir_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (bus.redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) begin
        q_inst[wr_ptr_q] <= bus.ic_instr;
        q_pc[wr_ptr_q]   <= pc_q;
        wr_ptr_q         <= wr_ptr_q + QAW'(1);
      end
      if (deq) rd_ptr_q <= rd_ptr_q + QAW'(1);
      count_q <= count_q + {{QAW{1'b0}}, enq} - {{QAW{1'b0}}, deq};
    end
  end

  assign bus.ic_addr      = pc_q;
  assign bus.mem_req      = (state_q == S_MISS);
  assign bus.mem_req_addr = MEM_ADDR_W'(line_addr_q);
  assign bus.ic_fill_en   = (state_q == S_FILL);
  assign bus.ic_fill_addr = line_addr_q;
  assign bus.ic_fill_line = fill_line_q;
  assign bus.inst_valid   = !q_empty;
  assign bus.inst         = q_inst[rd_ptr_q];
  assign bus.inst_pc      = q_pc[rd_ptr_q];
  assign fetch_state      = state_q;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_miss_cnt     <= '0;
      perf_redirect_cnt <= '0;
      perf_qfull_cnt    <= '0;
    end else begin
      if (lookup_miss && (perf_miss_cnt != '1))         perf_miss_cnt     <= perf_miss_cnt + 32'd1;
      if (bus.redirect_valid && (perf_redirect_cnt != '1)) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      if ((state_q == S_LOOKUP) && bus.ic_hit && q_full && (perf_qfull_cnt != '1))
        perf_qfull_cnt <= perf_qfull_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cache/memory models, delivered-stream reference and refill
// scoreboard, with directed scenarios followed by a randomized run.
module tb_fetch_unit;
  localparam int VADDR_W    = 32;
  localparam int INST_W     = 32;
  localparam int LINE_W     = 128;
  localparam int MEM_ADDR_W = 32;
  localparam int QDEPTH     = 4;
  localparam logic [31:0] BOOT_PC = 32'h0000_1000;

  logic       clk;
  logic       reset;
  logic [1:0] fetch_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_miss_cnt, perf_redirect_cnt, perf_qfull_cnt;
`endif

  fetch_unit_if #(.VADDR_W(VADDR_W), .INST_W(INST_W), .LINE_W(LINE_W), .MEM_ADDR_W(MEM_ADDR_W)) bus ();

  fetch_unit #(
    .VADDR_W(VADDR_W), .INST_W(INST_W), .LINE_W(LINE_W), .MEM_ADDR_W(MEM_ADDR_W),
    .BOOT_PC(BOOT_PC), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .fetch_state(fetch_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_miss_cnt(perf_miss_cnt),
    .perf_redirect_cnt(perf_redirect_cnt),
    .perf_qfull_cnt(perf_qfull_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // bench state
  int n_vec, n_err, n_deliv;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        c_valid [16];
  logic [23:0] c_tag   [16];
  logic        all_hit, resp_en, force_rdy, red_req;
  logic [31:0] miss_once_pc, red_pc, prev_ic_addr;
  logic        outstanding, rdy_prev, red_prev, req_prev;
  int          resp_cnt, dly_min, dly_max, dr_pct;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'hF;
    return {inst_of(b + 32'd12), inst_of(b + 32'd8), inst_of(b + 32'd4), inst_of(b)};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: monitor outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic step();
    logic [31:0] a;
    logic        pulse;
    @(negedge clk);
    if (reset) begin
      if (red_prev) check("flush_after_redirect", bus.inst_valid, 1'b0);
      check("fill_timing", bus.ic_fill_en, rdy_prev);
      check("req_fill_exclusive", bus.mem_req & bus.ic_fill_en, 1'b0);
      if (outstanding) check("req_held", bus.mem_req, 1'b1);
      if (bus.mem_req && !req_prev) begin
        check("req_addr", bus.mem_req_addr, prev_ic_addr & ~32'hF);
        exp_q.push_back(prev_ic_addr & ~32'hF);
        outstanding = 1'b1;
        resp_cnt = $urandom_range(dly_max, dly_min);
      end
      if (bus.ic_fill_en) begin
        if (exp_q.size() == 0) begin
          check("fill_unexpected", bus.ic_fill_en, 1'b0);
        end else begin
          a = exp_q.pop_front();
          check("fill_addr", bus.ic_fill_addr, a);
          check("fill_line", bus.ic_fill_line, line_of(a));
        end
        c_valid[bus.ic_fill_addr[7:4]] = 1'b1;
        c_tag[bus.ic_fill_addr[7:4]]   = bus.ic_fill_addr[31:8];
        miss_once_pc = 32'hFFFF_FFFF;
      end
    end
    prev_ic_addr = bus.ic_addr;
    req_prev     = bus.mem_req;

    pulse = 1'b0;
    bus.mem_data_rdy = 1'b0;
    bus.mem_data     = '0;
    if (force_rdy) begin
      bus.mem_data_rdy = 1'b1;
      bus.mem_data     = '1;
      force_rdy = 1'b0;
    end else if (outstanding && resp_en) begin
      if (resp_cnt == 0) begin
        pulse = 1'b1;
        bus.mem_data_rdy = 1'b1;
        bus.mem_data     = line_of(bus.mem_req_addr);
        outstanding = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
    rdy_prev = pulse;

    if (all_hit) bus.ic_hit = (bus.ic_addr != miss_once_pc);
    else         bus.ic_hit = c_valid[bus.ic_addr[7:4]] && (c_tag[bus.ic_addr[7:4]] == bus.ic_addr[31:8]);
    bus.ic_instr  = inst_of(bus.ic_addr);
    bus.dec_ready = ($urandom_range(99, 0) < dr_pct);
    bus.redirect_valid = red_req;
    bus.redirect_pc    = red_pc;
    red_req = 1'b0;

    if (bus.redirect_valid) begin
      exp_pc = bus.redirect_pc & ~32'h3;
    end else if (reset && bus.inst_valid && bus.dec_ready) begin
      check("inst_pc", bus.inst_pc, exp_pc);
      check("inst", bus.inst, inst_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    red_prev = bus.redirect_valid && reset;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    exp_pc      = BOOT_PC;
    outstanding = 1'b0;
    rdy_prev    = 1'b0;
    red_prev    = 1'b0;
    req_prev    = 1'b0;
    force_rdy   = 1'b0;
    red_req     = 1'b0;
    for (int i = 0; i < 16; i++) c_valid[i] = 1'b0;
    step();
    step();
  endtask

  task automatic wait_fill(input string tag);
    for (int i = 0; i < 20 && !bus.ic_fill_en; i++) step();
    check(tag, bus.ic_fill_en, 1'b1);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !bus.mem_req; i++) step();
    check(tag, bus.mem_req, 1'b1);
  endtask

  initial begin
    int d0;
    n_vec = 0; n_err = 0; n_deliv = 0;
    reset = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.ic_hit = 1'b0; bus.ic_instr = '0;
    bus.mem_data_rdy = 1'b0; bus.mem_data = '0; bus.dec_ready = 1'b0;
    all_hit = 1'b1; resp_en = 1'b1; dly_min = 3; dly_max = 3; dr_pct = 100;
    miss_once_pc = 32'hFFFF_FFFF; red_pc = '0; prev_ic_addr = '0; resp_cnt = 0;

    // reset values, then straight-line fetch with every lookup hitting
    do_reset();
    check("rst_ic_addr", bus.ic_addr, BOOT_PC);
    check("rst_inst_valid", bus.inst_valid, 1'b0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
    check("rst_fill_en", bus.ic_fill_en, 1'b0);
    check("rst_fill_addr", bus.ic_fill_addr, 32'h0);
    check("rst_fill_line", bus.ic_fill_line, 128'h0);
    reset = 1'b1;
    step();
    check("first_valid", bus.inst_valid, 1'b1);
    check("first_inst_pc", bus.inst_pc, BOOT_PC);
    repeat (8) step();
    check("pc_advance", bus.ic_addr, 32'h0000_1024);

    // miss at 0x1008: request, fill pulse, then refetch
    do_reset();
    miss_once_pc = 32'h0000_1008;
    reset = 1'b1;
    wait_req("miss_req_seen");
    check("miss_req_addr", bus.mem_req_addr, 32'h0000_1000);
    wait_fill("miss_fill_seen");
    check("miss_fill_addr", bus.ic_fill_addr, 32'h0000_1000);
    step();
    step();
    check("refetch_valid", bus.inst_valid, 1'b1);
    check("refetch_pc", bus.inst_pc, 32'h0000_1008);

    // backpressure: queue fills to QDEPTH and PC freezes, then drains in order
    do_reset();
    dr_pct = 0;
    reset = 1'b1;
    repeat (8) step();
    check("full_pc_frozen", bus.ic_addr, BOOT_PC + 32'(4 * QDEPTH));
    check("full_head_pc", bus.inst_pc, BOOT_PC);
    dr_pct = 100;
    d0 = n_deliv;
    repeat (8) step();
    check("drain_count", 32'(n_deliv - d0), 32'd8);

    // redirect with three entries queued
    do_reset();
    dr_pct = 0;
    reset = 1'b1;
    repeat (3) step();
    check("three_queued_pc", bus.ic_addr, 32'h0000_100C);
    red_req = 1'b1; red_pc = 32'h0000_2002;
    step();
    step();
    check("redir_flushed", bus.inst_valid, 1'b0);
    check("redir_pc", bus.ic_addr, 32'h0000_2000);
    dr_pct = 100;
    step();
    check("redir_first_pc", bus.inst_pc, 32'h0000_2000);
    repeat (4) step();

    // redirect while a miss is outstanding
    do_reset();
    miss_once_pc = 32'h0000_1008;
    dly_min = 4; dly_max = 4;
    reset = 1'b1;
    wait_req("rmiss_req_seen");
    red_req = 1'b1; red_pc = 32'h0000_3000;
    step();
    wait_fill("rmiss_fill_seen");
    step();
    check("rmiss_pc", bus.ic_addr, 32'h0000_3000);
    step();
    check("rmiss_valid", bus.inst_valid, 1'b1);
    check("rmiss_first_pc", bus.inst_pc, 32'h0000_3000);
    repeat (4) step();

    // reset in the middle of a miss, then a stray memory response
    do_reset();
    miss_once_pc = 32'h0000_1008;
    resp_en = 1'b0;
    reset = 1'b1;
    wait_req("rst_miss_req_seen");
    #2 reset = 1'b0;
    #1 check("rst_req_async_drop", bus.mem_req, 1'b0);
    do_reset();
    miss_once_pc = 32'hFFFF_FFFF;
    resp_en = 1'b1;
    reset = 1'b1;
    check("rst_boot_pc", bus.ic_addr, BOOT_PC);
    force_rdy = 1'b1;
    step();
    step();
    check("late_rdy_no_fill", bus.ic_fill_en, 1'b0);
    check("late_rdy_no_req", bus.mem_req, 1'b0);
    check("late_rdy_pc", bus.ic_addr, 32'h0000_1008);

    // randomized run against the cache/memory models
    do_reset();
    all_hit = 1'b0; dly_min = 0; dly_max = 4; dr_pct = 70;
    reset = 1'b1;
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99, 0) < 4) begin
        red_req = 1'b1;
        red_pc  = (($urandom_range(1, 0) == 0) ? 32'h0000_4000 : 32'h0000_1000) | 32'($urandom_range(12'hFFF, 0));
      end
      step();
    end
    check("random_progress", (n_deliv - d0) > 200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised next-generation fetch stage. Holds the PC, looks up the instruction cache, runs the miss/refill handshake with memory and buffers fetched instructions in a QDEPTH-entry queue that decouples fetch from decode. Handles branch redirects, including a redirect that arrives mid-miss. Sits between the instruction cache / memory arbiter and the decode stage.

Parameters:
VADDR_W, 32, virtual PC width
INST_W, 32, instruction width; PC increment = INST_W/8
LINE_W, 128, cache line width; LINE_W/8 bytes per line, power of 2
MEM_ADDR_W, 32, memory request address width
BOOT_PC, 32'h0000_1000, PC loaded at reset
QDEPTH, 4, instruction queue entries, power of 2, >=2

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
redirect_valid  in  1  branch hit: redirect fetch this cycle
redirect_pc  in  VADDR_W  redirect target
ic_addr  out  VADDR_W  lookup address (= PC), combinational from PC register
ic_hit  in  1  cache hit for ic_addr, same cycle
ic_instr  in  INST_W  instruction for ic_addr, valid when ic_hit
ic_fill_en  out  1  one-cycle pulse: cache writes ic_fill_line at ic_fill_addr
ic_fill_addr  out  VADDR_W  line-aligned fill address
ic_fill_line  out  LINE_W  refill data
mem_req  out  1  memory read request, level, held until mem_data_rdy
mem_req_addr  out  MEM_ADDR_W  line-aligned request address (zero-extended/truncated PC)
mem_data_rdy  in  1  memory response valid, one cycle
mem_data  in  LINE_W  response line
dec_ready  in  1  decode accepts head instruction
inst_valid  out  1  queue non-empty
inst  out  INST_W  head instruction
inst_pc  out  VADDR_W  PC of head instruction

Behaviour:
- Reset (reset=0): PC=BOOT_PC, state=LOOKUP, queue empty, inst_valid=0, inst/inst_pc=0, mem_req=0, mem_req_addr=0, ic_fill_en=0, ic_fill_addr=0, ic_fill_line=0, pending redirect cleared. Reset asserted mid-miss abandons the request; mem_req drops asynchronously.
- redirect_pc low log2(INST_W/8) bits are forced to 0.
- States: LOOKUP, MISS, FILL.
- LOOKUP: ic_hit & queue not full & !redirect_valid -> enqueue {ic_instr, PC}, PC += INST_W/8 (wraps modulo 2^VADDR_W). !ic_hit & !redirect_valid -> MISS, latch line address = PC with low log2(LINE_W/8) bits cleared. Queue full & hit -> hold PC, no enqueue.
- MISS: mem_req=1, mem_req_addr=latched line address. mem_data_rdy -> capture mem_data, go to FILL. mem_data_rdy outside MISS is ignored.
- FILL: ic_fill_en=1 for exactly one cycle with the captured line and address, then LOOKUP. Hit-after-miss latency: request to fill 1 cycle, refetched instruction in queue 2 cycles after mem_data_rdy.
- Redirect in LOOKUP: queue flushed, PC=redirect_pc next cycle, no enqueue that cycle.
- Redirect in MISS or FILL: queue flushed immediately; target stored as pending; the outstanding request completes and the line is filled, never dropped; on return to LOOKUP, PC=pending target. A later redirect overwrites the pending one.
- Queue: dequeue when inst_valid & dec_ready. Simultaneous enqueue and dequeue is allowed when full. Redirect beats dequeue: flushed, dequeue ignored. inst/inst_pc are registered from head entry; 1-cycle hit-to-inst_valid latency.
- ic_fill_en and mem_req are never asserted in the same cycle.

Optional Feature:
FETCH_PERF_CNT_EN: adds outputs perf_miss_cnt[31:0] (+1 on each LOOKUP->MISS), perf_redirect_cnt[31:0] (+1 per redirect_valid cycle) and perf_qfull_cnt[31:0] (+1 per LOOKUP cycle with hit & queue full). Counters saturate at 32'hFFFF_FFFF and clear on reset. Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
Reset release, ic_hit=1 always, dec_ready=1 -> inst_pc sequence 0x1000,0x1004,0x1008..., first inst_valid one cycle after release.
PC 0x1008 misses -> mem_req=1 with addr 0x1000 until mem_data_rdy. Next cycle ic_fill_en=1, ic_fill_addr=0x1000. Then 0x1008 is enqueued.
dec_ready=0 with hits -> exactly QDEPTH entries queued, PC frozen at BOOT_PC+4*QDEPTH. dec_ready=1 -> in-order drain, no loss.
redirect_valid with redirect_pc=0x2002 while 3 entries are queued -> inst_valid=0 next cycle, next fetch at 0x2000.
Redirect to 0x3000 during MISS -> mem_req held until response, fill pulse, first queued inst_pc=0x3000, no stale instruction queued.
Reset driven low during MISS -> mem_req=0 immediately. After release, PC=0x1000 and the late mem_data_rdy is ignored.
